// File: rtl/echo_depth_capture.sv
// Per-scan-line first-echo depth and peak capture with a small valid/ready result queue.
// Optional build macro ECHO_AVG_EN: detection and peak run on a 4-sample moving average.
module echo_depth_capture #(
  parameter int ADC_W      = 10,
  parameter int DEPTH_W    = 8,
  parameter int LINE_W     = 7,
  parameter int NUM_LINES  = 128,
  parameter int BLANK_CM   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               increment,
  input  logic               transmit,
  input  logic               receive,
  input  logic               markers,
  input  logic [ADC_W-1:0]   echo_sample,
  input  logic [ADC_W-1:0]   threshold,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] out_depth,
  output logic [ADC_W-1:0]   out_peak,
  output logic [LINE_W-1:0]  out_line,
  output logic               overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DEPTH_W-1:0] NO_ECHO   = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = NO_ECHO - DEPTH_W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, LISTEN, REPORT} state_t;

  state_t             state;
  logic [LINE_W-1:0]  line_idx;
  logic [LINE_W-1:0]  cap_line;
  logic [ADC_W-1:0]   thr_lat;
  logic [ADC_W-1:0]   peak;
  logic [ADC_W-1:0]   det_sample;
  logic [DEPTH_W-1:0] depth_cnt;
  logic [DEPTH_W-1:0] depth_lat;
  logic               found;
  logic               tx_accept;
  logic               eligible;

  logic               push;
  logic               pop;
  logic               push_ok;
  logic               full;
  logic               empty;
  logic [DEPTH_W-1:0] push_depth;
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [DEPTH_W-1:0] mem_depth [FIFO_DEPTH];
  logic [ADC_W-1:0]   mem_peak  [FIFO_DEPTH];
  logic [LINE_W-1:0]  mem_line  [FIFO_DEPTH];

  function automatic logic [DEPTH_W-1:0] sat_inc(input logic [DEPTH_W-1:0] v);
    return (v >= DEPTH_MAX) ? DEPTH_MAX : v + DEPTH_W'(1);
  endfunction

  function automatic logic [LINE_W-1:0] wrap_inc(input logic [LINE_W-1:0] v);
    return (v == LINE_W'(NUM_LINES - 1)) ? '0 : v + LINE_W'(1);
  endfunction

  // Transmit is ignored while listening; everywhere else it (re)arms a capture.
  assign tx_accept = transmit && (state != LISTEN);
  assign eligible  = (state == LISTEN) && receive && (depth_cnt >= DEPTH_W'(BLANK_CM));

`ifdef ECHO_AVG_EN
  logic [ADC_W-1:0] hist_p0 [4];
  logic [ADC_W+1:0] avg_sum;

  assign avg_sum    = (ADC_W+2)'(hist_p0[0]) + (ADC_W+2)'(hist_p0[1])
                    + (ADC_W+2)'(hist_p0[2]) + (ADC_W+2)'(hist_p0[3]);
  assign det_sample = avg_sum[ADC_W+1:2];

  // Stage p0: sample history; the comparator sees the average one clock late.
  always_ff @(posedge clock) begin
    if (reset || tx_accept) begin
      for (int i = 0; i < 4; i++) hist_p0[i] <= '0;
    end else begin
      hist_p0[0] <= echo_sample;
      for (int i = 1; i < 4; i++) hist_p0[i] <= hist_p0[i-1];
    end
  end
`else
  assign det_sample = echo_sample;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      line_idx  <= '0;
      cap_line  <= '0;
      thr_lat   <= '0;
      depth_cnt <= '0;
      depth_lat <= '0;
      peak      <= '0;
      found     <= 1'b0;
    end else begin
      if (increment) line_idx <= wrap_inc(line_idx);
      if (tx_accept) begin
        cap_line  <= line_idx;
        thr_lat   <= threshold;
        depth_cnt <= '0;
        depth_lat <= '0;
        peak      <= '0;
        found     <= 1'b0;
      end
      case (state)
        IDLE:   if (transmit) state <= ARMED;
        ARMED:  if (!transmit && receive) state <= LISTEN;
        LISTEN: begin
          if (!receive) begin
            state <= REPORT;
          end else begin
            if (markers) depth_cnt <= sat_inc(depth_cnt);
            // Crossing depth uses the count before any same-cycle marker.
            if (eligible) begin
              if (det_sample > peak) peak <= det_sample;
              if (!found && (det_sample >= thr_lat)) begin
                found     <= 1'b1;
                depth_lat <= depth_cnt;
              end
            end
          end
        end
        REPORT: state <= transmit ? ARMED : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push       = (state == REPORT);
  assign push_depth = found ? depth_lat : NO_ECHO;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_depth[wr_ptr[AW-1:0]] <= push_depth;
      mem_peak[wr_ptr[AW-1:0]]  <= peak;
      mem_line[wr_ptr[AW-1:0]]  <= cap_line;
    end
  end

  // Storage is not reset, so the head is masked to zero while the queue is empty.
  assign out_depth = out_valid ? mem_depth[rd_ptr[AW-1:0]] : '0;
  assign out_peak  = out_valid ? mem_peak[rd_ptr[AW-1:0]]  : '0;
  assign out_line  = out_valid ? mem_line[rd_ptr[AW-1:0]]  : '0;

endmodule

// File: doc/echo_depth_capture.md
Name: echo_depth_capture

Overview:
- Sits directly downstream of the ultrasound pulse/receive FSM and the echo ADC.
- Consumes the FSM strobes (increment, transmit, receive, markers) and the digitised echo amplitude, and produces one result per scan line: first-echo depth in cm, peak amplitude and line index.
- Results are queued in a small FIFO behind a valid/ready interface for the display/plotting stage.

Parameters:
- ADC_W, 10, echo sample width (unsigned)
- DEPTH_W, 8, depth/marker counter width in cm
- LINE_W, 7, scan-line index width
- NUM_LINES, 128, line index wraps from NUM_LINES-1 to 0
- BLANK_CM, 2, markers to ignore after receive opens (transducer ring-down)
- FIFO_DEPTH, 4, result queue entries (power of 2, >=2)

Ports:
- clock  in  1  system clock (the 5 MHz FSM clock domain)
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- increment  in  1  one-cycle strobe: advance scan line
- transmit  in  1  one-cycle strobe: pulse fired, arm capture
- receive  in  1  level, high for the whole listen window
- markers  in  1  one-cycle strobe per cm of travel during receive
- echo_sample  in  ADC_W  echo amplitude, sampled every clock
- threshold  in  ADC_W  detection level, sampled at transmit
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- out_depth  out  DEPTH_W  first-echo depth in cm; all-ones = no echo
- out_peak  out  ADC_W  max sample after blanking
- out_line  out  LINE_W  line index the result belongs to
- overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset: state IDLE; line_idx=0; all counters and latches 0; FIFO empty; out_valid=0; out_depth/out_peak/out_line=0; overflow=0. Reset mid-window discards the in-flight result.
- line_idx increments on each increment strobe and wraps NUM_LINES-1 -> 0. If increment and transmit occur in the same cycle, the capture takes the pre-increment value.
- FSM states:
  - IDLE: on transmit, latch line_idx and threshold, clear depth_cnt/peak/found, go ARMED.
  - ARMED: on receive=1, go LISTEN. A second transmit re-arms and re-latches.
  - LISTEN: each markers strobe sets depth_cnt+=1, saturating at all-ones-1. A sample is eligible when depth_cnt>=BLANK_CM. For eligible samples: peak=max(peak, echo_sample); the first eligible sample >= threshold sets found=1 and depth=depth_cnt. A marker and a crossing in the same cycle use the pre-increment depth_cnt. On the first cycle with receive=0, go REPORT. A transmit strobe during LISTEN is ignored.
  - REPORT: one cycle. Push {depth (or all-ones if !found), peak, line}, then go IDLE; a transmit in this cycle goes to ARMED.
- Push timing: if REPORT is cycle N, the entry is written at the end of N. If the FIFO was empty, out_valid=1 in cycle N+1.
- FIFO:
  - Push when full: entry dropped, overflow set (sticky until reset).
  - Push and pop in the same cycle when full: the pop frees the slot and the push succeeds.
  - Outputs present the head combinationally from registered storage.
  - Head data must stay stable while out_valid & !out_ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Arithmetic: all comparisons are unsigned. depth_cnt never reaches all-ones, so it stays distinct from the no-echo code.

Optional Feature:
- ECHO_AVG_EN defined: detection and peak use a 4-sample moving average (sum of the last 4 samples >>2, ADC_W+2-bit sum). The averaging history clears at transmit. This adds 1 cycle of delay between echo_sample and the comparator; the depth latched is depth_cnt at comparator time.
- Undefined: raw echo_sample is used directly with no added delay.

Test Plan:
- Single line, threshold=300, samples 100 except 500 in the cycle after the 5th marker, out_ready=1 -> out_valid 1 cycle after REPORT with depth=5, peak=500, line=0.
- Echo 800 before BLANK_CM (after 1st marker), nothing later above threshold -> depth=255, peak=max of post-blank samples only.
- 130 increment+transmit+receive cycles -> out_line sequence ends ...127, 0, 1; no gaps.
- out_ready=0 for 6 lines with FIFO_DEPTH=4 -> first 4 results retained in order, overflow=1, head unchanged while stalled; releasing ready drains exactly 4 entries.
- Reset asserted mid-LISTEN, then a normal line -> no result from the aborted window, next result has line=0, overflow=0.
- ECHO_AVG_EN: single-sample spike 1000 with baseline 0, threshold=300 -> no detection (average 250), peak=250.
